jtframe_db9_joy: RTL and testbench

DB9 joystick scanner for boards without an I/O controller (e.g. Neptuno-class targets). It sits directly upstream of the base framework block and produces the `joystick1`/`joystick2` words that block forwards to the core. Each scan drives `JOY_SELECT` through the Mega Drive 6-button sequence, stepping on `hs` rising edges. It auto-detects the pad type on each port, either 6-button, 3-button or Atari/SMS, and publishes active-high 12-bit words atomically once per scan.

---
 rtl/jtframe_db9_joy.sv | 208 ++++++++++++++++++++
 tb/tb_jtframe_db9_joy.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_db9_joy.sv
// DB9 joystick scanner: walks JOY_SELECT through the Mega Drive 6-button sequence on hs steps,
// auto-detects 6-button / 3-button / Atari pads. Optional OSD toggle via `define JTFRAME_DB9_OSD_EN.
module jtframe_db9_joy #(
   parameter int unsigned IDLE_LINES = 32
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        sdram_init,
   input  logic        hs,
   input  logic [5:0]  joy1_bus,
   input  logic [5:0]  joy2_bus,
   output logic        JOY_SELECT,
   output logic [11:0] joystick1,
   output logic [11:0] joystick2,
   output logic        osd_en
);

   localparam int unsigned BUS_W = 6;
   localparam int unsigned NPORT = 2;
   localparam int unsigned PH_W  = 3;
   localparam int unsigned CNT_W = (IDLE_LINES > 1) ? $clog2(IDLE_LINES) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LINES - 1);

   typedef struct packed {
      logic mode;
      logic start;
      logic z;
      logic y;
      logic x;
      logic c;
      logic b;
      logic a;
      logic u;
      logic d;
      logic l;
      logic r;
   } joy_t;

   typedef enum logic [1:0] {
      ST_WAIT_INIT,
      ST_IDLE,
      ST_SCAN
   } state_t;

   logic                         hs_meta_q, hs_sync_q, hs_prev_q, step_q;
   logic [NPORT-1:0][BUS_W-1:0]  bus_meta_q, bus_q;
   state_t                       state_q, state_d;
   logic [PH_W-1:0]              phase_q, phase_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         sel_q, sel_d;
   joy_t [NPORT-1:0]             cap_q, cap_d;
   joy_t [NPORT-1:0]             joy_q, joy_d;
   logic [NPORT-1:0]             md_q, md_d;
   logic [NPORT-1:0]             six_q, six_d;

   // Synchronisers, hs edge detector and FSM state registers
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         hs_meta_q  <= 1'b0;
         hs_sync_q  <= 1'b0;
         hs_prev_q  <= 1'b0;
         step_q     <= 1'b0;
         bus_meta_q <= '1;
         bus_q      <= '1;
         state_q    <= ST_WAIT_INIT;
         phase_q    <= '0;
         cnt_q      <= '0;
         sel_q      <= 1'b1;
         cap_q      <= '0;
         joy_q      <= '0;
         md_q       <= '0;
         six_q      <= '0;
      end else begin
         hs_meta_q  <= hs;
         hs_sync_q  <= hs_meta_q;
         hs_prev_q  <= hs_sync_q;
         step_q     <= hs_sync_q & ~hs_prev_q;
         bus_meta_q <= {joy2_bus, joy1_bus};
         bus_q      <= bus_meta_q;
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         cap_q      <= cap_d;
         joy_q      <= joy_d;
         md_q       <= md_d;
         six_q      <= six_d;
      end
   end

   // Next state, per-phase bus capture and commit of both words
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      joy_d   = joy_q;
      md_d    = md_q;
      six_d   = six_q;

      if (sdram_init) begin
         state_d = ST_WAIT_INIT;
         phase_d = '0;
         cnt_d   = '0;
      end else if (step_q) begin
         case (state_q)
            ST_WAIT_INIT: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
            ST_IDLE: begin
               if (cnt_q == IDLE_LAST) begin
                  state_d = ST_SCAN;
                  phase_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SCAN: begin
               for (int p = 0; p < NPORT; p++) begin
                  case (phase_q)
                     3'd0: begin
                        cap_d[p].u = ~bus_q[p][0];
                        cap_d[p].d = ~bus_q[p][1];
                        cap_d[p].l = ~bus_q[p][2];
                        cap_d[p].r = ~bus_q[p][3];
                        cap_d[p].b = ~bus_q[p][4];
                        cap_d[p].c = ~bus_q[p][5];
                     end
                     3'd1: begin
                        cap_d[p].a     = ~bus_q[p][4];
                        cap_d[p].start = ~bus_q[p][5];
                        md_d[p]        = (bus_q[p][3:2] == 2'b00);
                     end
                     3'd5: six_d[p] = md_q[p] & (bus_q[p][3:0] == 4'b0000);
                     3'd6: begin
                        cap_d[p].z    = ~bus_q[p][0];
                        cap_d[p].y    = ~bus_q[p][1];
                        cap_d[p].x    = ~bus_q[p][2];
                        cap_d[p].mode = ~bus_q[p][3];
                     end
                     3'd7: begin
                        joy_d[p] = cap_q[p];
                        if (!six_q[p]) begin
                           joy_d[p].x    = 1'b0;
                           joy_d[p].y    = 1'b0;
                           joy_d[p].z    = 1'b0;
                           joy_d[p].mode = 1'b0;
                        end
                        // Atari/SMS pads keep B/C from P0 and have no A/Start
                        if (!md_q[p]) begin
                           joy_d[p].a     = 1'b0;
                           joy_d[p].start = 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
               if (phase_q == 3'd7) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  phase_d = phase_q + 3'd1;
               end
            end
            default: state_d = ST_WAIT_INIT;
         endcase
      end

      sel_d = (state_d == ST_SCAN) ? ~phase_d[0] : 1'b1;
   end

   assign JOY_SELECT = sel_q;
   assign joystick1  = joy_q[0];
   assign joystick2  = joy_q[1];

`ifdef JTFRAME_DB9_OSD_EN
   logic osd_q, osd_d, combo_q, combo_d, combo_c, commit_c;

   assign commit_c = step_q & ~sdram_init & (state_q == ST_SCAN) & (phase_q == 3'd7);
   assign combo_c  = joy_d[0].start & joy_d[0].d;

   // Toggle only on the first commit of a held Start+Down combo
   always_comb begin
      osd_d   = osd_q;
      combo_d = combo_q;
      if (commit_c) begin
         combo_d = combo_c;
         if (combo_c && !combo_q) osd_d = ~osd_q;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         osd_q   <= 1'b0;
         combo_q <= 1'b0;
      end else begin
         osd_q   <= osd_d;
         combo_q <= combo_d;
      end
   end

   assign osd_en = osd_q;
`else
   assign osd_en = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_db9_joy.sv
// Scoreboard bench for jtframe_db9_joy: behavioural pad models on both ports, expected words per scan.
module tb_jtframe_db9_joy;

   localparam int unsigned IDLE = 32;
`ifdef JTFRAME_DB9_OSD_EN
   localparam logic OSD_ON = 1'b1;
`else
   localparam logic OSD_ON = 1'b0;
`endif

   // pad kinds
   localparam int K_SIX = 0, K_THREE = 1, K_ATARI = 2, K_NONE = 3;

   logic        clk_sys, rst_n, sdram_init, hs;
   logic [5:0]  joy1_bus, joy2_bus;
   logic        JOY_SELECT, osd_en;
   logic [11:0] joystick1, joystick2;

   int vectors = 0, miscompares = 0, commits = 0;
   int falls = 0, hi_lines = 0;
   int kind1 = K_NONE, kind2 = K_NONE;
   logic [11:0] w1 = '0, w2 = '0;
   logic frc2 = 1'b0;
   logic [11:0] com_j1 = '0, com_j2 = '0;
   logic osd_exp = 1'b0, combo_prev = 1'b0;

   typedef struct {
      logic [11:0] j1;
      logic [11:0] j2;
   } exp_t;
   exp_t sb[$];

   jtframe_db9_joy #(.IDLE_LINES(IDLE)) dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .sdram_init (sdram_init),
      .hs         (hs),
      .joy1_bus   (joy1_bus),
      .joy2_bus   (joy2_bus),
      .JOY_SELECT (JOY_SELECT),
      .joystick1  (joystick1),
      .joystick2  (joystick2),
      .osd_en     (osd_en)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // hs: 20-cycle lines, high for 5 cycles
   initial begin
      hs = 1'b0;
      forever begin
         repeat (15) @(negedge clk_sys);
         hs = 1'b1;
         repeat (5) @(negedge clk_sys);
         hs = 1'b0;
      end
   end

   // Pad pins from the pressed buttons (word layout), select level and select-low pulse count f
   function automatic logic [5:0] pad_bus(input int kind, input logic [11:0] w, input logic frc,
                                          input logic sel, input int f);
      logic [5:0] b;
      b = 6'h3F;
      if (kind == K_SIX || kind == K_THREE) begin
         if (sel) begin
            if (kind == K_SIX && f == 3)        b = ~{w[6], w[5], w[11], w[7], w[8], w[9]};
            else if (frc && f == 3)             b = {~w[6], ~w[5], 4'b0000};
            else                                b = ~{w[6], w[5], w[0], w[1], w[2], w[3]};
         end else begin
            if (kind == K_SIX && f == 3)        b = {~w[10], ~w[4], 4'b0000};
            else if (kind == K_SIX && f == 4)   b = {~w[10], ~w[4], 4'b1111};
            else                                b = {~w[10], ~w[4], 2'b00, ~w[2], ~w[3]};
         end
      end else if (kind == K_ATARI) begin
         b = ~{w[6], w[5], w[0], w[1], w[2], w[3]};
      end
      return b;
   endfunction

   // What each pad type can report
   function automatic logic [11:0] exp_word(input int kind, input logic [11:0] w);
      case (kind)
         K_SIX:   return w;
         K_THREE: return w & 12'h47F;
         K_ATARI: return w & 12'h06F;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [11:0] rand_btn();
      logic [11:0] w;
      w = 12'($urandom);
      if (w[3]) w[2] = 1'b0;
      if (w[0]) w[1] = 1'b0;
      return w;
   endfunction

   assign joy1_bus = pad_bus(kind1, w1, 1'b0, JOY_SELECT, falls);
   assign joy2_bus = pad_bus(kind2, w2, frc2, JOY_SELECT, falls);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_scan(input int k1, input logic [11:0] a, input int k2, input logic [11:0] b,
                           input logic f);
      exp_t e;
      kind1 = k1; w1 = a; kind2 = k2; w2 = b; frc2 = f;
      e.j1 = exp_word(k1, a);
      e.j2 = exp_word(k2, b);
      sb.push_back(e);
   endtask

   task automatic wait_commit();
      int start, t;
      start = commits;
      t = 0;
      while (commits == start && t < 4000) begin
         @(negedge clk_sys);
         t++;
      end
      chk("commit_seen", 32'(commits != start), 32'd1);
   endtask

   // Monitor: tracks select pulses like a pad would, pops the scoreboard on each commit
   initial begin : monitor
      logic sel_prev, hs_prev;
      exp_t e;
      sel_prev = 1'b1;
      hs_prev  = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (!JOY_SELECT) hi_lines = 0;
         else if (hs && !hs_prev) hi_lines++;
         if (hi_lines >= 4) falls = 0;
         if (sel_prev && !JOY_SELECT) falls++;
         if (!sel_prev && JOY_SELECT && falls == 4) begin
            commits++;
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_commit: got j1=0x%0h j2=0x%0h, expected no commit",
                        joystick1, joystick2);
            end else begin
               e = sb.pop_front();
`ifdef JTFRAME_DB9_OSD_EN
               if (e.j1[10] && e.j1[2] && !combo_prev) osd_exp = ~osd_exp;
               combo_prev = e.j1[10] & e.j1[2];
`endif
               chk("joystick1", 32'(joystick1), 32'(e.j1));
               chk("joystick2", 32'(joystick2), 32'(e.j2));
               chk("osd_en", 32'(osd_en), 32'(osd_exp));
               com_j1 = e.j1;
               com_j2 = e.j2;
            end
         end
         sel_prev = JOY_SELECT;
         hs_prev  = hs;
      end
   end

   // Driver
   initial begin
      int lines, t;
      logic fell;
      rst_n = 1'b0;
      sdram_init = 1'b1;
      repeat (4) @(negedge clk_sys);
      chk("rst_select", 32'(JOY_SELECT), 32'd1);
      chk("rst_joystick1", 32'(joystick1), 32'd0);
      chk("rst_joystick2", 32'(joystick2), 32'd0);
      chk("rst_osd", 32'(osd_en), 32'd0);
      rst_n = 1'b1;

      repeat (100) begin
         @(posedge hs);
         repeat (8) @(negedge clk_sys);
         chk("init_hold", 32'({JOY_SELECT, joystick1, joystick2}), 32'h0100_0000);
      end

      // 6-button A+Z+Right on port 1, nothing on port 2
      set_scan(K_SIX, 12'h211, K_NONE, 12'h000, 1'b0);
      @(negedge hs);
      @(negedge clk_sys);
      sdram_init = 1'b0;
      // WAIT_INIT exit, IDLE lines to reach P0, then one more line until select drops in P1
      lines = 0;
      fell = 1'b0;
      while (!fell && lines < 200) begin
         @(posedge hs);
         lines++;
         repeat (10) @(negedge clk_sys);
         if (!JOY_SELECT) fell = 1'b1;
      end
      chk("first_select_low_line", 32'(lines), 32'(IDLE + 2));
      wait_commit();

      // 3-button Start+Up on port 2, with pins forced low in P6
      set_scan(K_NONE, 12'h000, K_THREE, 12'h408, 1'b1);
      wait_commit();
      // Atari fire1+Left on port 1
      set_scan(K_ATARI, 12'h022, K_THREE, 12'h408, 1'b0);
      wait_commit();

      // Abort during P4: nothing commits, rescan starts over from WAIT_INIT
      set_scan(K_SIX, 12'h080, K_ATARI, 12'h008, 1'b0);
      t = 0;
      while (!(falls == 2 && JOY_SELECT) && t < 4000) begin
         @(negedge clk_sys);
         t++;
      end
      chk("reach_p4", 32'(falls == 2 && JOY_SELECT), 32'd1);
      sdram_init = 1'b1;
      @(negedge clk_sys);
      chk("abort_select", 32'(JOY_SELECT), 32'd1);
      repeat (3) @(posedge hs);
      repeat (8) @(negedge clk_sys);
      chk("abort_hold_select", 32'(JOY_SELECT), 32'd1);
      chk("abort_hold_j1", 32'(joystick1), 32'(com_j1));
      chk("abort_hold_j2", 32'(joystick2), 32'(com_j2));
      sdram_init = 1'b0;
      wait_commit();

      // Start+Down held three scans, released, held again
      repeat (3) begin
         set_scan(K_THREE, 12'h404, K_NONE, 12'h000, 1'b0);
         wait_commit();
      end
      chk("osd_after_hold", 32'(osd_en), 32'(OSD_ON));
      set_scan(K_THREE, 12'h000, K_NONE, 12'h000, 1'b0);
      wait_commit();
      set_scan(K_THREE, 12'h404, K_NONE, 12'h000, 1'b0);
      wait_commit();
      chk("osd_after_rehold", 32'(osd_en), 32'd0);

      repeat (20) begin
         int k1, k2;
         logic f;
         k1 = int'($urandom_range(0, 3));
         k2 = int'($urandom_range(0, 3));
         f  = (k2 == K_THREE) ? 1'($urandom_range(0, 1)) : 1'b0;
         set_scan(k1, rand_btn(), k2, rand_btn(), f);
         wait_commit();
      end

      // Reset in the middle of a scan
      t = 0;
      while (falls != 1 && t < 4000) begin
         @(negedge clk_sys);
         t++;
      end
      chk("reach_p1", 32'(falls), 32'd1);
      rst_n = 1'b0;
      @(negedge clk_sys);
      chk("midreset_select", 32'(JOY_SELECT), 32'd1);
      chk("midreset_j1", 32'(joystick1), 32'd0);
      chk("midreset_j2", 32'(joystick2), 32'd0);
      chk("midreset_osd", 32'(osd_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
